// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types for the pipeline hazard scoreboard.
// Revision : 1.0
// ============================================================================
package hazard_pkg;

   // Shadow-stage index fields are sized for the widest supported register file.
   localparam int IDX_MAX_W = 8;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic                 valid;
      logic [IDX_MAX_W-1:0] rd;
      logic                 regwrite;
      logic                 load;
      logic [IDX_MAX_W-1:0] rs1;
      logic [IDX_MAX_W-1:0] rs2;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '0;

   function automatic fwd_sel_t fwd_pick(
      input stage_t               m,
      input stage_t               w,
      input logic [IDX_MAX_W-1:0] rs
   );
      fwd_sel_t sel;
      sel = FWD_RF;
      if (w.valid && w.regwrite && (w.rd != '0) && (w.rd == rs)) begin
         sel = FWD_WB;
      end
      // The younger producer in M overrides an older one in W.
      if (m.valid && m.regwrite && (m.rd != '0) && (m.rd == rs)) begin
         sel = FWD_MEM;
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stage_reg
// Brief    : One shadow pipeline stage; hold keeps contents, bubble clears it.
// Revision : 1.0
// ============================================================================
module hazard_stage_reg
   import hazard_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   hold_i,
   input  logic   bubble_i,
   input  stage_t stage_i,
   output stage_t stage_o
);

   stage_t stage_q;
   stage_t stage_d;

   always_comb begin
      stage_d = stage_i;
      if (hold_i) begin
         stage_d = stage_q;
      end else if (bubble_i) begin
         stage_d = STAGE_BUBBLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= STAGE_BUBBLE;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign stage_o = stage_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Stall/flush/forward control for a 5-stage pipeline with slow loads.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int MEM_WAIT = 0,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_d,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              regwrite_d,
   input  logic              load_d,
   input  logic              pcsrc_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic [1:0]        fwd_a_e,
   output logic [1:0]        fwd_b_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic             WAIT_EN   = (MEM_WAIT > 0);
   localparam logic [2:0]       WAIT_INIT = 3'(MEM_WAIT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   stage_t           d_stage;
   stage_t           e_q;
   stage_t           m_q;
   stage_t           w_q;
   state_t           state_q;
   state_t           state_d;
   logic [2:0]       wcnt_q;
   logic [2:0]       wcnt_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d;
   logic             br;
   logic             lwstall;
   logic             br_taken;
   logic             unused_w_fields;

   always_comb begin
      d_stage          = STAGE_BUBBLE;
      d_stage.valid    = valid_d;
      d_stage.rd       = IDX_MAX_W'(rd_d);
      d_stage.regwrite = regwrite_d;
      d_stage.load     = load_d;
      d_stage.rs1      = IDX_MAX_W'(rs1_d);
      d_stage.rs2      = IDX_MAX_W'(rs2_d);
   end

   // W is filled with bubbles while M is frozen so a result is never retired twice.
   hazard_stage_reg u_stage_e (
      .clk      (clk),
      .rst_n    (reset),
      .hold_i   (stall_e),
      .bubble_i (flush_e),
      .stage_i  (d_stage),
      .stage_o  (e_q)
   );

   hazard_stage_reg u_stage_m (
      .clk      (clk),
      .rst_n    (reset),
      .hold_i   (stall_m),
      .bubble_i (1'b0),
      .stage_i  (e_q),
      .stage_o  (m_q)
   );

   hazard_stage_reg u_stage_w (
      .clk      (clk),
      .rst_n    (reset),
      .hold_i   (1'b0),
      .bubble_i (stall_m),
      .stage_i  (m_q),
      .stage_o  (w_q)
   );

   assign unused_w_fields = ^{w_q.load, w_q.rs1, w_q.rs2};

   assign br      = pcsrc_e & e_q.valid;
   assign lwstall = valid_d & e_q.valid & e_q.load & (e_q.rd != '0)
                  & ((e_q.rd == d_stage.rs1) | (e_q.rd == d_stage.rs2));

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      br_taken = 1'b0;
      case (state_q)
         RUN: begin
            if (br) begin
               flush_d  = 1'b1;
               flush_e  = 1'b1;
               br_taken = 1'b1;
            end else if (lwstall) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
            // Nothing stalls M in RUN, so a valid load in E always advances.
            if (WAIT_EN && e_q.valid && e_q.load) begin
               state_d = WAIT;
               wcnt_d  = WAIT_INIT;
            end
         end
         WAIT: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            if (wcnt_q <= 3'd1) begin
               state_d = RUN;
               wcnt_d  = 3'd0;
            end else begin
               wcnt_d = wcnt_q - 3'd1;
            end
         end
         default: begin
            state_d = RUN;
            wcnt_d  = 3'd0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_d && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (br_taken && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         wcnt_q      <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fwd_a_e   = fwd_pick(m_q, w_q, e_q.rs1);
   assign fwd_b_e   = fwd_pick(m_q, w_q, e_q.rs2);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Two scoreboard configurations against an instruction-level model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_scoreboard;

   localparam int N = 2;

   typedef struct {
      bit v;
      int rd;
      bit rw;
      bit ld;
      int rs1;
      int rs2;
   } ins_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_d;
   logic [4:0] rs1_d;
   logic [4:0] rs2_d;
   logic [4:0] rd_d;
   logic       regwrite_d;
   logic       load_d;
   logic       pcsrc_e;

   logic        sf0, sd0, se0, sm0, fd0, fe0;
   logic [1:0]  fa0, fb0;
   logic [3:0]  sc0, fc0;
   logic        sf1, sd1, se1, sm1, fd1, fe1;
   logic [1:0]  fa1, fb1;
   logic [15:0] sc1, fc1;

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_AW(5), .MEM_WAIT(0), .CNT_W(4)) u_dut0 (
      .clk(clk), .reset(reset), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .pcsrc_e(pcsrc_e),
      .stall_f(sf0), .stall_d(sd0), .stall_e(se0), .stall_m(sm0),
      .flush_d(fd0), .flush_e(fe0), .fwd_a_e(fa0), .fwd_b_e(fb0),
      .stall_cnt(sc0), .flush_cnt(fc0)
   );

   hazard_scoreboard #(.MEM_WAIT(3)) u_dut3 (
      .clk(clk), .reset(reset), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .pcsrc_e(pcsrc_e),
      .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1),
      .flush_d(fd1), .flush_e(fe1), .fwd_a_e(fa1), .fwd_b_e(fb1),
      .stall_cnt(sc1), .flush_cnt(fc1)
   );

   // Reference model: instructions resident in E, M and W plus freeze cycles left.
   ins_t me[N];
   ins_t mm[N];
   ins_t mw[N];
   int   freeze[N];
   int   scnt[N];
   int   fcnt[N];
   int   wait_cfg[N];
   int   cnt_max[N];

   logic [31:0] last_ctl[N];
   logic [31:0] last_fa[N];
   logic [31:0] last_fb[N];
   logic [31:0] last_sc[N];
   logic [31:0] last_fc[N];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic ins_t mk(input bit v, input int rd, input bit rw, input bit ld,
                               input int r1, input int r2);
      ins_t t;
      t.v = v; t.rd = rd; t.rw = rw; t.ld = ld; t.rs1 = r1; t.rs2 = r2;
      return t;
   endfunction

   function automatic int model_fwd(input int k, input int rs);
      if (rs != 0 && mm[k].v && mm[k].rw && mm[k].rd == rs) return 2;
      if (rs != 0 && mw[k].v && mw[k].rw && mw[k].rd == rs) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] got_ctl(input int k);
      return (k == 0) ? {26'd0, sf0, sd0, se0, sm0, fd0, fe0}
                      : {26'd0, sf1, sd1, se1, sm1, fd1, fe1};
   endfunction
   function automatic logic [31:0] got_fa(input int k);
      return (k == 0) ? {30'd0, fa0} : {30'd0, fa1};
   endfunction
   function automatic logic [31:0] got_fb(input int k);
      return (k == 0) ? {30'd0, fb0} : {30'd0, fb1};
   endfunction
   function automatic logic [31:0] got_sc(input int k);
      return (k == 0) ? {28'd0, sc0} : {16'd0, sc1};
   endfunction
   function automatic logic [31:0] got_fc(input int k);
      return (k == 0) ? {28'd0, fc0} : {16'd0, fc1};
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         me[k] = mk(0, 0, 0, 0, 0, 0);
         mm[k] = me[k];
         mw[k] = me[k];
         freeze[k] = 0;
         scnt[k] = 0;
         fcnt[k] = 0;
      end
   endtask

   // Called just after a rising edge; returns just after the next rising edge.
   task automatic step(input bit v, input int r1, input int r2, input int rd,
                       input bit rw, input bit ld, input bit pc);
      bit [5:0] ec[N];
      bit       frz[N];
      bit       brk[N];
      bit       lw;
      valid_d = v; rs1_d = 5'(r1); rs2_d = 5'(r2); rd_d = 5'(rd);
      regwrite_d = rw; load_d = ld; pcsrc_e = pc;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         frz[k] = (freeze[k] > 0);
         brk[k] = pc && me[k].v;
         lw = v && me[k].v && me[k].ld && me[k].rd != 0 && (me[k].rd == r1 || me[k].rd == r2);
         if (frz[k])      ec[k] = 6'b111100;
         else if (brk[k]) ec[k] = 6'b000011;
         else if (lw)     ec[k] = 6'b110001;
         else             ec[k] = 6'b000000;
         check($sformatf("ctl%0d", k), got_ctl(k), 32'(ec[k]));
         check($sformatf("fwda%0d", k), got_fa(k), 32'(model_fwd(k, me[k].rs1)));
         check($sformatf("fwdb%0d", k), got_fb(k), 32'(model_fwd(k, me[k].rs2)));
         check($sformatf("stallcnt%0d", k), got_sc(k), 32'(scnt[k]));
         check($sformatf("flushcnt%0d", k), got_fc(k), 32'(fcnt[k]));
         last_ctl[k] = got_ctl(k);
         last_fa[k]  = got_fa(k);
         last_fb[k]  = got_fb(k);
         last_sc[k]  = got_sc(k);
         last_fc[k]  = got_fc(k);
      end
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (ec[k][4] && scnt[k] < cnt_max[k]) scnt[k]++;
         if (!frz[k] && brk[k] && fcnt[k] < cnt_max[k]) fcnt[k]++;
         if (frz[k]) begin
            mw[k] = mk(0, 0, 0, 0, 0, 0);
            freeze[k]--;
         end else begin
            mw[k] = mm[k];
            mm[k] = me[k];
            me[k] = ec[k][0] ? mk(0, 0, 0, 0, 0, 0) : mk(v, rd, rw, ld, r1, r2);
            freeze[k] = (mm[k].v && mm[k].ld) ? wait_cfg[k] : 0;
         end
      end
      #1;
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
      regwrite_d = 0; load_d = 0; pcsrc_e = 0;
      reset = 1'b0;
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("rst_ctl%0d", k), got_ctl(k), 32'd0);
         check($sformatf("rst_fwda%0d", k), got_fa(k), 32'd0);
         check($sformatf("rst_fwdb%0d", k), got_fb(k), 32'd0);
         check($sformatf("rst_scnt%0d", k), got_sc(k), 32'd0);
         check($sformatf("rst_fcnt%0d", k), got_fc(k), 32'd0);
      end
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      wait_cfg[0] = 0; wait_cfg[1] = 3;
      cnt_max[0]  = 15; cnt_max[1] = 65535;
      reset = 1'b1;
      valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
      regwrite_d = 0; load_d = 0; pcsrc_e = 0;
      model_clear();
      #2;
      do_reset();

      // ALU result forwarded from M, then from W.
      step(1, 1, 2, 5, 1, 0, 0);
      step(1, 5, 0, 7, 1, 0, 0);
      step(1, 5, 0, 8, 1, 0, 0);
      check("alu_fwd_mem", last_fa[0], 32'd2);
      nop();
      check("alu_fwd_wb", last_fa[0], 32'd1);

      // Load-use: one bubble, then forward from W.
      do_reset();
      step(1, 0, 0, 6, 1, 1, 0);
      step(1, 1, 6, 9, 1, 0, 0);
      check("lwstall_ctl", last_ctl[0], 32'b110001);
      step(1, 1, 6, 9, 1, 0, 0);
      check("lwstall_once", last_ctl[0], 32'd0);
      nop();
      check("lwuse_fwd_b", last_fb[0], 32'd1);
      check("lwuse_scnt", last_sc[0], 32'd1);

      // Branch wins over a simultaneous load-use stall.
      do_reset();
      step(1, 0, 0, 6, 1, 1, 0);
      step(1, 0, 6, 9, 1, 0, 1);
      check("br_over_lw", last_ctl[0], 32'b000011);
      nop();
      check("br_fcnt", last_fc[0], 32'd1);
      check("br_scnt", last_sc[0], 32'd0);

      // Slow load freezes all stages; a branch waiting in E is taken afterwards.
      do_reset();
      step(1, 0, 0, 6, 1, 1, 0);
      step(1, 1, 2, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 1);
         check($sformatf("wait_frz%0d", i), last_ctl[1], 32'b111100);
      end
      step(0, 0, 0, 0, 0, 0, 1);
      check("wait_br_after", last_ctl[1], 32'b000011);
      nop();
      check("wait_br_fcnt", last_fc[1], 32'd1);

      // x0 never forwards or stalls.
      do_reset();
      step(1, 0, 0, 0, 1, 1, 0);
      step(1, 0, 0, 3, 1, 0, 0);
      check("x0_nostall", last_ctl[0], 32'd0);
      nop();
      check("x0_fwd_a", last_fa[0], 32'd0);

      // Reset in the middle of a slow-load freeze.
      do_reset();
      step(1, 0, 0, 6, 1, 1, 0);
      nop();
      nop();
      check("frz_before_rst", last_ctl[1], 32'b111100);
      do_reset();
      nop();
      check("frz_gone", last_ctl[1], 32'd0);

      // Counter saturation with twenty load-use stalls.
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, 7, 1, 1, 0);
         step(1, 7, 0, 9, 1, 0, 0);
      end
      nop();
      check("scnt_sat", last_sc[0], 32'd15);

      // Random traffic on a small register set to provoke hazards.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001: Parameter REG_AW, default 5, register-index width.
REQ-002: Parameter MEM_WAIT, default 0, extra freeze cycles a load spends in M (0..7).
REQ-003: Parameter CNT_W, default 16, performance-counter width.
REQ-004: clk  input  1  single clock; all state on rising edge.
REQ-005: reset  input  1  asynchronous, active-low reset.
REQ-006: valid_d  input  1  decode-stage instruction valid.
REQ-007: rs1_d, rs2_d, rd_d  input  REG_AW each  decode-stage source and destination indices.
REQ-008: regwrite_d, load_d  input  1 each  decode-stage instruction writes the regfile / is a load.
REQ-009: pcsrc_e  input  1  taken branch or jump resolved in E.
REQ-010: stall_f, stall_d, stall_e, stall_m  output  1 each  hold the named pipeline register.
REQ-011: flush_d, flush_e  output  1 each  clear the D or E pipeline register to a bubble.
REQ-012: fwd_a_e, fwd_b_e  output  2 each  E operand select: 00 regfile, 01 W result, 10 M ALU result.
REQ-013: stall_cnt, flush_cnt  output  CNT_W each  saturating performance counters.

Function
REQ-014: Shadow stages E, M and W each hold {valid, rd, regwrite, load}; E also holds rs1 and rs2.
REQ-015: D->E transfer each cycle unless stall_e; when flush_e=1, E loads a bubble (valid=0).
REQ-016: E->M and M->W transfer each cycle unless stall_m; while stall_m=1, M holds and W loads a bubble.
REQ-017: Forward select: 10 if M.valid & M.regwrite & M.rd!=0 & M.rd==E.rs; else 01 if the same condition holds for W; else 00. M has priority over W.
REQ-018: lwstall = valid_d & E.valid & E.load & E.rd!=0 & (E.rd==rs1_d | E.rd==rs2_d).
REQ-019: br = pcsrc_e & E.valid.
REQ-020: FSM states RUN and WAIT; wait counter wcnt, 3 bits.
REQ-021: RUN->WAIT when MEM_WAIT>0 and a valid load moves E->M; wcnt loads MEM_WAIT.
REQ-022: In WAIT, wcnt decrements each cycle; WAIT->RUN on the cycle wcnt reaches 0. WAIT lasts exactly MEM_WAIT cycles.
REQ-023: MEM_WAIT=0: the FSM never leaves RUN.
REQ-024: In WAIT: stall_f = stall_d = stall_e = stall_m = 1 and flush_d = flush_e = 0. A pending br is honoured in the first RUN cycle.
REQ-025: In RUN with br: flush_d = flush_e = 1 and all stalls = 0. A branch overrides a simultaneous lwstall.
REQ-026: In RUN with lwstall and no br: stall_f = stall_d = 1, flush_e = 1, stall_e = stall_m = 0. Latency is one bubble.
REQ-027: Otherwise all stall and flush outputs are 0.
REQ-028: Index 0 never causes forwarding or a stall.
REQ-029: Stall, flush and forward outputs are combinational from state and inputs.
REQ-030: stall_cnt increments on every cycle stall_d=1.
REQ-031: flush_cnt increments on every cycle br is honoured.
REQ-032: Both counters are registered and saturate at all-ones (no wrap).

Reset
REQ-033: While reset=0, all shadow valid bits, indices, wcnt and both counters are 0, and the FSM is in RUN.
REQ-034: Under reset, all stall and flush outputs are 0 and fwd_a_e = fwd_b_e = 00.
REQ-035: Reset asserted during WAIT aborts the wait immediately; no freeze persists after release.

Structure
REQ-036: Package hazard_pkg holds the fwd_sel_t enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10), the stage_t struct, and the state_t enum {RUN, WAIT}.
REQ-037: One sub-module, hazard_stage_reg, is a stage_t register with hold and bubble inputs, instantiated for E, M and W.

Verification
REQ-038: add x5 in E, then use x5 in the next instruction, MEM_WAIT=0 -> fwd_a_e=10; one cycle later, with x5 in W, fwd_a_e=01.
REQ-039: lw x6 in E, with rs2_d=6 in D -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; the next cycle fwd_b_e=01; stall_cnt=1.
REQ-040: lwstall and pcsrc_e in the same cycle -> flush_d=flush_e=1, stall_d=0, flush_cnt=1, stall_cnt unchanged.
REQ-041: MEM_WAIT=3, lw enters M -> all four stalls high for 3 cycles, flushes low, then RUN; a branch in E during the wait flushes on cycle 4.
REQ-042: rd=x0 writer followed by a reader of x0 -> fwd=00, no stall.
REQ-043: Reset pulse in the second WAIT cycle; CNT_W=4 with 20 load-use stalls -> outputs 0 after reset; stall_cnt holds at 15.
